// File: rtl/uart_frame_arbiter.sv
// uart_frame_arbiter
//
// Shares one UART TX FIFO between NUM_REQ report sources. Pending sources are
// arbitrated round-robin; the winner's payload is latched and sent as a fixed
// byte frame: SOF, ID, payload[15:8], payload[7:0] and, when
// UART_FRAME_CSUM_EN is defined, an XOR checksum of the four preceding bytes.
// With UART_FRAME_CSUM_EN undefined the frame is 4 bytes and LO returns to IDLE.
//
// Ports:
//   clk         system clock
//   reset_n     asynchronous active-low reset
//   req         level request per source, held until ack
//   payload     flattened payloads, source i at [i*PAYLOAD_W +: PAYLOAD_W]
//   ack         one-hot, one-cycle pulse when a payload is latched
//   fifo_full   TX FIFO full flag
//   fifo_write  one-cycle FIFO write strobe (registered)
//   fifo_data   byte presented with fifo_write (registered)
//   busy        high from grant until the last frame byte is written

module uart_frame_arbiter #(
  parameter int unsigned NUM_REQ   = 4,
  parameter int unsigned PAYLOAD_W = 14,
  parameter int unsigned DATA_SIZE = 8,
  parameter logic [7:0]  SOF_BYTE  = 8'hA5
) (
  input  logic                           clk,
  input  logic                           reset_n,
  input  logic [NUM_REQ-1:0]             req,
  input  logic [NUM_REQ*PAYLOAD_W-1:0]   payload,
  output logic [NUM_REQ-1:0]             ack,
  input  logic                           fifo_full,
  output logic                           fifo_write,
  output logic [DATA_SIZE-1:0]           fifo_data,
  output logic                           busy
);

  localparam int unsigned PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  localparam logic [2:0] StIdle = 3'd0;
  localparam logic [2:0] StSof  = 3'd1;
  localparam logic [2:0] StId   = 3'd2;
  localparam logic [2:0] StHi   = 3'd3;
  localparam logic [2:0] StLo   = 3'd4;
`ifdef UART_FRAME_CSUM_EN
  localparam logic [2:0] StCsum = 3'd5;
`endif

  logic [2:0]           state_q, state_d;
  logic [PTR_W-1:0]     ptr_q, ptr_d;
  logic [15:0]          pl_q, pl_d;
  logic [2:0]           id_q, id_d;
  logic [NUM_REQ-1:0]   ack_q, ack_d;
  logic                 wr_q, wr_d;
  logic [DATA_SIZE-1:0] data_q, data_d;
  logic                 busy_q, busy_d;

  // Unpack the flat payload bus so the winner can be selected by index.
  logic [PAYLOAD_W-1:0] pl_arr [NUM_REQ];
  for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
    assign pl_arr[i] = payload[i*PAYLOAD_W +: PAYLOAD_W];
  end

  // Circular search starting at the pointer; first pending source wins.
  logic             grant_valid;
  logic [PTR_W-1:0] grant_idx;
  logic [PTR_W-1:0] ptr_next;

  always_comb begin
    int unsigned cand;
    cand        = 0;
    grant_valid = 1'b0;
    grant_idx   = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      cand = (32'(ptr_q) + k) % NUM_REQ;
      if (!grant_valid && req[PTR_W'(cand)]) begin
        grant_valid = 1'b1;
        grant_idx   = PTR_W'(cand);
      end
    end
  end

  assign ptr_next = (grant_idx == PTR_W'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;

  // Byte to send in the current state and the state that follows it.
  logic [7:0] id_byte;
  logic [7:0] cur_byte;
  logic [2:0] byte_next;

  assign id_byte = {5'b0, id_q};

`ifdef UART_FRAME_CSUM_EN
  logic [7:0] csum_byte;
  assign csum_byte = SOF_BYTE ^ id_byte ^ pl_q[15:8] ^ pl_q[7:0];
`endif

  always_comb begin
    cur_byte  = 8'h00;
    byte_next = StIdle;
    case (state_q)
      StSof: begin
        cur_byte  = SOF_BYTE;
        byte_next = StId;
      end
      StId: begin
        cur_byte  = id_byte;
        byte_next = StHi;
      end
      StHi: begin
        cur_byte  = pl_q[15:8];
        byte_next = StLo;
      end
      StLo: begin
        cur_byte  = pl_q[7:0];
`ifdef UART_FRAME_CSUM_EN
        byte_next = StCsum;
`else
        byte_next = StIdle;
`endif
      end
`ifdef UART_FRAME_CSUM_EN
      StCsum: begin
        cur_byte  = csum_byte;
        byte_next = StIdle;
      end
`endif
      default: begin
        cur_byte  = 8'h00;
        byte_next = StIdle;
      end
    endcase
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    pl_d    = pl_q;
    id_d    = id_q;
    ack_d   = '0;
    wr_d    = 1'b0;
    data_d  = data_q;
    busy_d  = busy_q;
    if (state_q == StIdle) begin
      if (grant_valid) begin
        ack_d   = NUM_REQ'(1) << grant_idx;
        pl_d    = 16'(pl_arr[grant_idx]);
        id_d    = 3'(grant_idx);
        busy_d  = 1'b1;
        ptr_d   = ptr_next;
        state_d = StSof;
      end
    end else if (!fifo_full) begin
      // A full FIFO stalls the state, so each byte is written exactly once.
      wr_d    = 1'b1;
      data_d  = DATA_SIZE'(cur_byte);
      state_d = byte_next;
      if (byte_next == StIdle) begin
        busy_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= StIdle;
      ptr_q   <= '0;
      pl_q    <= '0;
      id_q    <= '0;
      ack_q   <= '0;
      wr_q    <= 1'b0;
      data_q  <= '0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      pl_q    <= pl_d;
      id_q    <= id_d;
      ack_q   <= ack_d;
      wr_q    <= wr_d;
      data_q  <= data_d;
      busy_q  <= busy_d;
    end
  end

  assign ack        = ack_q;
  assign fifo_write = wr_q;
  assign fifo_data  = data_q;
  assign busy       = busy_q;

endmodule
